conv_quant_ctrl: RTL
====================

// Module: conv_quant_ctrl
// PURPOSE
//  Sequencer for the per-tile abs-max tracker behind the 16-lane conv array: clears the tracker,
//  gates its tracking enable with conv valid, issues the end-of-tile finish pulse, waits for the
//  tracker's finish flag, then captures the abs-max and derives a requantisation right-shift.
// PARAMETERS
//  DATA_W     32  width of tracker abs-max result (treated as unsigned)
//  OUT_W      8   signed width of requantised activations; target max = 2^(OUT_W-1)-1
//  PIX_CNT_W  16  width of per-tile result-vector count
//  TIMEOUT    15  cycles allowed from conv_finish to finish_flag before error
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous active-low reset
//  start        in   1          tile start request; accepted only in IDLE
//  pix_total    in   PIX_CNT_W  result vectors in tile; sampled on accepted start
//  conv_valid   in   1          conv array presents one result vector this cycle
//  tracker_clr  out  1          1-cycle synchronous clear to tracker min/max registers
//  track_en     out  1          tracker accumulate enable (tracker computeClear input)
//  conv_finish  out  1          1-cycle end-of-tile pulse to tracker
//  finish_flag  in   1          tracker reports abs-max valid
//  max_abs_in   in   DATA_W     tracker abs-max result
//  busy         out  1          high in every state except IDLE
//  done         out  1          1-cycle completion pulse
//  max_abs_out  out  DATA_W     captured abs-max; held until next accepted start
//  shift        out  5          requant right-shift, 0..DATA_W-OUT_W; held like max_abs_out
//  sat          out  1          abs-max not representable even at max shift; held
//  timeout_err  out  1          finish_flag missing; held until next accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; pixel and wait counters 0. Reset mid-tile aborts with no done.
//  FSM: IDLE -> CLEAR -> TRACK -> FINISH -> WAIT -> SCALE -> DONE -> IDLE.
//  IDLE: start=1 -> latch pix_total, clear max_abs_out/shift/sat/timeout_err; if pix_total==0 go
//   DONE directly (empty tile, outputs stay 0), else CLEAR. start in any other state ignored.
//  CLEAR: tracker_clr=1 for exactly 1 cycle; -> TRACK.
//  TRACK: track_en = conv_valid (combinational, only in TRACK); pixel counter +1 per conv_valid;
//   conv_valid on count==pix_total-1 -> FINISH. conv_valid outside TRACK ignored, never gated on.
//  FINISH: conv_finish=1 for 1 cycle; wait counter cleared; -> WAIT.
//  WAIT: counter +1 per cycle; finish_flag=1 -> capture max_abs_in, -> SCALE. finish_flag in the
//   same cycle counter reaches TIMEOUT still counts as success. Counter==TIMEOUT, no flag ->
//   timeout_err=1, max_abs_out=0, shift=0, -> DONE. finish_flag outside WAIT ignored.
//  Nominal tracker latency: flag 7 cycles after conv_finish pulse; TIMEOUT must exceed this.
//  SCALE (1 cycle): shift = smallest s in [0, DATA_W-OUT_W] with (max_abs_out >> s) <= 2^(OUT_W-1)-1,
//   logical shift, unsigned compare. None satisfies -> shift=DATA_W-OUT_W, sat=1 (covers
//   0x8000_0000 from abs of most-negative value). -> DONE.
//  DONE: done=1 for 1 cycle; -> IDLE. start in DONE ignored; earliest new start is next cycle.
//  Latency: start edge to done = 4 + pix_total stall-free cycles + flag wait + 1 (SCALE).
//  busy=1 from cycle after accepted start through DONE inclusive.
// TESTING
//  1 pix_total=4, conv_valid 4 consecutive cycles, flag 7 cyc after conv_finish, max_abs_in=100
//    -> track_en high exactly 4 cycles, one conv_finish, done, max_abs_out=100, shift=0, sat=0.
//  2 pix_total=3 with conv_valid gaps (1,0,0,1,0,1) -> track_en mirrors valid only in TRACK,
//    conv_finish 1 cycle after 3rd valid; max_abs_in=0x0000_1000 -> shift=6 (0x1000>>6=64).
//  3 max_abs_in=0x7F00_0000 -> shift=24, sat=0; max_abs_in=0x8000_0000 -> shift=24, sat=1.
//  4 finish_flag never asserted -> done exactly TIMEOUT+1 cycles after conv_finish,
//    timeout_err=1, max_abs_out=0; next start clears timeout_err.
//  5 start with pix_total=0 -> done 1 cycle after start, no tracker_clr/conv_finish, outputs 0;
//    start pulses while busy -> ignored, pix_total not re-latched.
//  6 rst_n low during TRACK -> immediate IDLE, all outputs 0, no done; new tile runs cleanly.

Source files
------------

// File: rtl/conv_quant_ctrl_if.sv
// ----------------------------------------------------------------------------
// conv_quant_ctrl_if
//   Bundles the tile-control, conv-array and abs-max-tracker signals of the
//   conv_quant_ctrl sequencer into one interface.
//   master : the environment (tile scheduler, conv array, tracker) side
//   slave  : the sequencer side
// Signals
//   start, pix_total          tile start request and result-vector count
//   conv_valid                conv array result-vector strobe
//   tracker_clr, track_en,
//   conv_finish               controls toward the abs-max tracker
//   finish_flag, max_abs_in   tracker result handshake
//   busy, done                sequencer status
//   max_abs_out, shift, sat,
//   timeout_err               per-tile requantisation result
// ----------------------------------------------------------------------------
interface conv_quant_ctrl_if #(
  parameter int DATA_W    = 32,
  parameter int PIX_CNT_W = 16
);
  logic                 start;
  logic [PIX_CNT_W-1:0] pix_total;
  logic                 conv_valid;
  logic                 tracker_clr;
  logic                 track_en;
  logic                 conv_finish;
  logic                 finish_flag;
  logic [DATA_W-1:0]    max_abs_in;
  logic                 busy;
  logic                 done;
  logic [DATA_W-1:0]    max_abs_out;
  logic [4:0]           shift;
  logic                 sat;
  logic                 timeout_err;

  modport master (
    output start, pix_total, conv_valid, finish_flag, max_abs_in,
    input  tracker_clr, track_en, conv_finish, busy, done,
           max_abs_out, shift, sat, timeout_err
  );

  modport slave (
    input  start, pix_total, conv_valid, finish_flag, max_abs_in,
    output tracker_clr, track_en, conv_finish, busy, done,
           max_abs_out, shift, sat, timeout_err
  );
endinterface

// File: rtl/conv_quant_ctrl.sv
// ----------------------------------------------------------------------------
// conv_quant_ctrl
//   Per-tile sequencer for the abs-max tracker behind the 16-lane conv array.
//   Clears the tracker, gates its accumulate enable with conv_valid for
//   pix_total result vectors, pulses conv_finish, waits (bounded) for the
//   tracker's finish_flag, captures the abs-max and derives the smallest
//   right-shift that brings it into the signed OUT_W activation range.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts a tile without done
//   bus    conv_quant_ctrl_if.slave (start/pix_total/conv_valid/finish_flag/
//          max_abs_in in; tracker_clr/track_en/conv_finish/busy/done/
//          max_abs_out/shift/sat/timeout_err out)
// ----------------------------------------------------------------------------
module conv_quant_ctrl #(
  parameter int DATA_W    = 32,
  parameter int OUT_W     = 8,
  parameter int PIX_CNT_W = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  conv_quant_ctrl_if.slave   bus
);

  localparam int MAX_SHIFT = DATA_W - OUT_W;
  localparam int WAIT_W    = $clog2(TIMEOUT + 1);
  // 2^(OUT_W-1)-1, the largest positive requantised activation
  localparam logic [DATA_W-1:0] TARGET_MAX =
    {{(DATA_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_TRACK, S_FINISH, S_WAIT, S_SCALE, S_DONE
  } state_t;

  state_t               state;
  logic [PIX_CNT_W-1:0] pix_total_q;
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic [WAIT_W-1:0]    wait_cnt;

  // Smallest logical right-shift that fits v into TARGET_MAX; falls back to
  // MAX_SHIFT when nothing fits (calc_sat flags that case).
  function automatic logic [4:0] calc_shift(input logic [DATA_W-1:0] v);
    logic [4:0] s;
    s = 5'(MAX_SHIFT);
    for (int i = MAX_SHIFT; i >= 0; i--) begin
      if ((v >> i) <= TARGET_MAX) s = 5'(i);
    end
    return s;
  endfunction

  function automatic logic calc_sat(input logic [DATA_W-1:0] v);
    return (v >> MAX_SHIFT) > TARGET_MAX;
  endfunction

  // Enable follows conv_valid combinationally so the tracker accumulates the
  // same cycle the vector is presented.
  assign bus.track_en = (state == S_TRACK) && bus.conv_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      pix_total_q     <= '0;
      pix_cnt         <= '0;
      wait_cnt        <= '0;
      bus.tracker_clr <= 1'b0;
      bus.conv_finish <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.max_abs_out <= '0;
      bus.shift       <= '0;
      bus.sat         <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.tracker_clr <= 1'b0;
      bus.conv_finish <= 1'b0;
      bus.done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pix_total_q     <= bus.pix_total;
            pix_cnt         <= '0;
            bus.max_abs_out <= '0;
            bus.shift       <= '0;
            bus.sat         <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.busy        <= 1'b1;
            if (bus.pix_total == '0) begin
              // empty tile: nothing to track, complete immediately
              state    <= S_DONE;
              bus.done <= 1'b1;
            end else begin
              state           <= S_CLEAR;
              bus.tracker_clr <= 1'b1;
            end
          end
        end
        S_CLEAR: state <= S_TRACK;
        S_TRACK: begin
          if (bus.conv_valid) begin
            pix_cnt <= pix_cnt + PIX_CNT_W'(1);
            if (pix_cnt == pix_total_q - PIX_CNT_W'(1)) begin
              state           <= S_FINISH;
              bus.conv_finish <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // wait_cnt+1 is the count reached this cycle; a flag arriving on
          // the cycle the count reaches TIMEOUT still wins.
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (bus.finish_flag) begin
            bus.max_abs_out <= bus.max_abs_in;
            state           <= S_SCALE;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            bus.timeout_err <= 1'b1;
            bus.max_abs_out <= '0;
            bus.shift       <= '0;
            state           <= S_DONE;
            bus.done        <= 1'b1;
          end
        end
        S_SCALE: begin
          bus.shift <= calc_shift(bus.max_abs_out);
          bus.sat   <= calc_sat(bus.max_abs_out);
          state     <= S_DONE;
          bus.done  <= 1'b1;
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
